// File: rtl/note_scroller_if.sv
`default_nettype none
// ============================================================================
// Module   : note_scroller_if
// Brief    : Control, song-ROM, player and lane-display signals of note_scroller.
// Revision : 1.0 - initial release
// ============================================================================
interface note_scroller_if #(
    parameter int CODE_W   = 2,
    parameter int WINDOW   = 10,
    parameter int SUBSTEPS = 7,
    parameter int ADDR_W   = 10,
    parameter int TICK_W   = 17,
    parameter int COMBO_W  = 8
);
    localparam int c_OFF_W = (SUBSTEPS > 1) ? $clog2(SUBSTEPS) : 1;

    logic                       start;
    logic [ADDR_W-1:0]          song_len;
    logic [TICK_W-1:0]          tick_period;
    logic [ADDR_W-1:0]          rom_addr;
    logic [CODE_W-1:0]          rom_data;
    logic                       hit;
    logic [CODE_W-1:0]          hit_code;
    logic                       ack;
    logic [WINDOW*CODE_W-1:0]   window;
    logic [c_OFF_W-1:0]         offset;
    logic [CODE_W-1:0]          judge_code;
    logic [COMBO_W-1:0]         combo;
    logic [COMBO_W-1:0]         max_combo;
    logic                       hit_ok;
    logic                       miss;
    logic                       busy;
    logic                       finish;

    modport master (
        output start, song_len, tick_period, rom_data, hit, hit_code, ack,
        input  rom_addr, window, offset, judge_code, combo, max_combo,
               hit_ok, miss, busy, finish
    );

    modport slave (
        input  start, song_len, tick_period, rom_data, hit, hit_code, ack,
        output rom_addr, window, offset, judge_code, combo, max_combo,
               hit_ok, miss, busy, finish
    );
endinterface
`default_nettype wire

// File: rtl/note_scroller.sv
`default_nettype none
// ============================================================================
// Module   : note_scroller
// Brief    : ROM-fed note lane scroller with head-slot hit judging and combo.
// Revision : 1.0 - initial release
// ============================================================================
module note_scroller #(
    parameter int CODE_W   = 2,
    parameter int WINDOW   = 10,
    parameter int SUBSTEPS = 7,
    parameter int ADDR_W   = 10,
    parameter int TICK_W   = 17,
    parameter int COMBO_W  = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    note_scroller_if.slave  bus
);
    localparam int c_OFF_W = (SUBSTEPS > 1) ? $clog2(SUBSTEPS) : 1;
    // One extra index bit so song_len+WINDOW never wraps.
    localparam int c_IDX_W = ADDR_W + 1;
    localparam logic [c_OFF_W-1:0] c_OFF_LAST   = c_OFF_W'(SUBSTEPS - 1);
    localparam logic [c_IDX_W-1:0] c_WINDOW_IDX = c_IDX_W'(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_len;
    logic [TICK_W-1:0]          r_period;
    logic [TICK_W-1:0]          r_tick;
    logic [c_OFF_W-1:0]         r_offset;
    logic [c_IDX_W-1:0]         r_index;
    logic [WINDOW*CODE_W-1:0]   r_window;
    logic [COMBO_W-1:0]         r_combo;
    logic [COMBO_W-1:0]         r_max;
    logic                       r_hit_ok;
    logic                       r_miss;

    logic                       w_run;
    logic                       w_start_ok;
    logic                       w_step;
    logic                       w_shift;
    logic [CODE_W-1:0]          w_slot0;
    logic                       w_match;
    logic                       w_bad_press;
    logic                       w_lost;
    logic [CODE_W-1:0]          w_incoming;
    logic [c_IDX_W-1:0]         w_index_inc;
    logic                       w_drained;
    logic [COMBO_W-1:0]         w_combo_inc;
    logic [WINDOW*CODE_W-1:0]   w_window_nxt;

    assign w_run       = (r_state == S_RUN);
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && (bus.song_len != '0);
    assign w_step      = w_run && (r_tick == r_period);
    assign w_shift     = w_step && (r_offset == c_OFF_LAST);
    assign w_slot0     = r_window[CODE_W-1:0];

    // A press is judged against the pre-shift head slot, so a matched note
    // leaving on the same edge is scored as a hit rather than lost.
    assign w_match     = w_run && bus.hit && (w_slot0 != '0) && (w_slot0 == bus.hit_code);
    assign w_bad_press = w_run && bus.hit && !w_match;
    assign w_lost      = w_shift && (w_slot0 != '0) && !w_match;

    assign w_incoming  = (r_index < {1'b0, r_len}) ? bus.rom_data : '0;
    assign w_index_inc = r_index + c_IDX_W'(1);
    assign w_drained   = (w_index_inc == ({1'b0, r_len} + c_WINDOW_IDX));
    assign w_combo_inc = (&r_combo) ? r_combo : (r_combo + COMBO_W'(1));

    always_comb begin
        w_window_nxt = r_window;
        if (w_match) begin
            w_window_nxt[CODE_W-1:0] = '0;
        end
        if (w_shift) begin
            w_window_nxt = {w_incoming, r_window[WINDOW*CODE_W-1:CODE_W]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_shift && w_drained) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                if (bus.ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len    <= '0;
            r_period <= '0;
            r_tick   <= '0;
            r_offset <= '0;
            r_index  <= '0;
            r_window <= '0;
            r_combo  <= '0;
            r_max    <= '0;
            r_hit_ok <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_hit_ok <= 1'b0;
            r_miss   <= 1'b0;
            if (w_start_ok) begin
                r_len    <= bus.song_len;
                r_period <= bus.tick_period;
                r_tick   <= '0;
                r_offset <= '0;
                r_index  <= '0;
                r_window <= '0;
                r_combo  <= '0;
                r_max    <= '0;
            end else if (w_run) begin
                r_tick   <= w_step ? '0 : (r_tick + TICK_W'(1));
                r_window <= w_window_nxt;
                if (w_step) begin
                    r_offset <= w_shift ? '0 : (r_offset + c_OFF_W'(1));
                end
                if (w_shift) begin
                    r_index <= w_index_inc;
                end
                if (w_match) begin
                    r_combo  <= w_combo_inc;
                    r_hit_ok <= 1'b1;
                    if (w_combo_inc > r_max) begin
                        r_max <= w_combo_inc;
                    end
                end else if (w_bad_press || w_lost) begin
                    r_combo <= '0;
                    r_miss  <= 1'b1;
                end
            end
        end
    end

    assign bus.rom_addr   = r_index[ADDR_W-1:0];
    assign bus.window     = r_window;
    assign bus.offset     = r_offset;
    assign bus.judge_code = w_slot0;
    assign bus.combo      = r_combo;
    assign bus.max_combo  = r_max;
    assign bus.hit_ok     = r_hit_ok;
    assign bus.miss       = r_miss;
    assign bus.busy       = w_run;
    assign bus.finish     = (r_state == S_FINISH);
endmodule
`default_nettype wire

// File: tb/tb_note_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scroller
// Brief    : Directed song table plus hand-built corner sequences for note_scroller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_scroller;
    localparam int CODE_W   = 2;
    localparam int WINDOW   = 10;
    localparam int SUBSTEPS = 7;
    localparam int ADDR_W   = 10;
    localparam int TICK_W   = 17;
    localparam int COMBO_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_scroller_if #(
        .CODE_W(CODE_W), .WINDOW(WINDOW), .SUBSTEPS(SUBSTEPS),
        .ADDR_W(ADDR_W), .TICK_W(TICK_W), .COMBO_W(COMBO_W)
    ) bus ();

    note_scroller #(
        .CODE_W(CODE_W), .WINDOW(WINDOW), .SUBSTEPS(SUBSTEPS),
        .ADDR_W(ADDR_W), .TICK_W(TICK_W), .COMBO_W(COMBO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Song ROM with one cycle of read latency
    logic [CODE_W-1:0] rom [0:7];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[2:0]];

    typedef struct {
        int          tp;
        int          len;
        logic [15:0] notes;   // note i at [2*i +: 2]
        logic [15:0] acts;    // 0 none, 1 correct press, 2 wrong colour
        int          hits;
        int          misses;
        int          combo;
        int          mx;
        int          dur;
    } vec_t;

    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [15:0] pk(input int a, input int b, input int c, input int d, input int e);
        pk = {6'd0, e[1:0], d[1:0], c[1:0], b[1:0], a[1:0]};
    endfunction

    function automatic vec_t mkv(input int tp, input int len, input logic [15:0] notes,
                                 input logic [15:0] acts, input int h, input int m,
                                 input int c, input int x, input int d);
        vec_t v;
        v.tp = tp; v.len = len; v.notes = notes; v.acts = acts;
        v.hits = h; v.misses = m; v.combo = c; v.mx = x; v.dur = d;
        return v;
    endfunction

    task automatic load_rom(input logic [15:0] notes);
        for (int i = 0; i < 8; i++) rom[i] = notes[2*i +: 2];
    endtask

    task automatic start_song(input int len, input int tp);
        bus.start       = 1'b1;
        bus.song_len    = ADDR_W'(len);
        bus.tick_period = TICK_W'(tp);
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.song_len = '0; bus.tick_period = '0;
        bus.hit = 1'b0; bus.hit_code = '0; bus.ack = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = '0;

        vecs[0] = mkv(1, 3, pk(1,2,1,0,0), pk(0,0,0,0,0), 0, 3, 0, 0, 183);
        vecs[1] = mkv(1, 3, pk(1,2,1,0,0), pk(1,1,1,0,0), 3, 0, 3, 3, 183);
        vecs[2] = mkv(1, 5, pk(1,1,2,3,1), pk(1,1,1,1,1), 5, 0, 3, 3, 211);
        vecs[3] = mkv(1, 3, pk(1,1,1,0,0), pk(1,1,2,0,0), 2, 2, 0, 2, 183);
        vecs[4] = mkv(2, 2, pk(3,0,0,0,0), pk(0,0,0,0,0), 0, 1, 0, 0, 253);
        vecs[5] = mkv(1, 4, pk(1,2,3,1,0), pk(1,1,0,0,0), 2, 2, 0, 2, 197);
        vecs[6] = mkv(3, 1, pk(2,0,0,0,0), pk(1,0,0,0,0), 1, 0, 1, 1, 309);

        // Reset state
        repeat (3) cyc();
        chk("reset_window", int'(bus.window != '0), 0);
        chk("reset_busy_finish", int'({bus.busy, bus.finish}), 0);
        chk("reset_combo_max", int'({bus.combo, bus.max_combo}), 0);
        chk("reset_pulses_addr", int'({bus.hit_ok, bus.miss} != 2'b00 || bus.rom_addr != '0), 0);
        rst = 1'b0;
        cyc();

        // Presses outside RUN and empty songs are ignored
        bus.hit = 1'b1; bus.hit_code = 2'd1;
        cyc();
        bus.hit = 1'b0;
        chk("idle_hit_ignored", int'(bus.miss | bus.hit_ok), 0);
        start_song(0, 1);
        chk("zero_len_ignored", int'(bus.busy), 0);
        cyc();

        // Empty-slot press, ignored restart, then a press on the shift edge
        load_rom(pk(2,1,0,0,0));
        start_song(2, 1);
        for (int n = 0; n <= 168; n++) begin
            if (n == 0)   chk("busy_after_start", int'(bus.busy), 1);
            if (n == 21)  chk("empty_hit_miss", int'({bus.miss, bus.hit_ok}), 2);
            if (n == 153) chk("pre_shift_slot0", int'(bus.judge_code), 2);
            if (n == 154) begin
                chk("coinc_pulses", int'({bus.hit_ok, bus.miss}), 2);
                chk("coinc_shifted_slot0", int'(bus.judge_code), 1);
                chk("coinc_combo", int'(bus.combo), 1);
                chk("coinc_offset", int'(bus.offset), 0);
            end
            if (n == 168) chk("coinc_song_finish", int'(bus.finish), 1);
            bus.hit = 1'b0; bus.start = 1'b0;
            if (n == 20)  begin bus.hit = 1'b1; bus.hit_code = 2'd1; end
            if (n == 30)  begin bus.start = 1'b1; bus.song_len = 10'd7; bus.tick_period = 17'd5; end
            if (n == 153) begin bus.hit = 1'b1; bus.hit_code = 2'd2; end
            cyc();
        end
        bus.hit = 1'b0; bus.start = 1'b0;
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        chk("ack_to_idle", int'({bus.busy, bus.finish}), 0);

        // Reset in the middle of a song with a nonzero max combo
        load_rom(pk(1,1,1,0,0));
        start_song(3, 1);
        for (int n = 0; n < 160; n++) begin
            if (n == 150) chk("max_before_reset", int'(bus.max_combo), 1);
            bus.hit = 1'b0;
            if (n == 146) begin bus.hit = 1'b1; bus.hit_code = 2'd1; end
            cyc();
        end
        bus.hit = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrun_reset_state", int'({bus.busy, bus.finish, bus.combo, bus.max_combo}), 0);
        chk("midrun_reset_lane", int'(bus.window != '0 || bus.offset != '0 || bus.rom_addr != '0), 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Song table
        for (int v = 0; v < 7; v++) begin
            int p, fin, hits, misses, nfin;
            p = SUBSTEPS * (vecs[v].tp + 1);
            nfin = (vecs[v].len + WINDOW) * p;
            fin = -1; hits = 0; misses = 0;
            load_rom(vecs[v].notes);
            start_song(vecs[v].len, vecs[v].tp);
            for (int n = 0; n < 3000 && fin < 0; n++) begin
                if (bus.hit_ok) hits++;
                if (bus.miss) misses++;
                if (bus.finish) fin = n;
                else begin
                    chk($sformatf("v%0d_offset_n%0d", v, n), int'(bus.offset),
                        (n / (vecs[v].tp + 1)) % SUBSTEPS);
                    chk($sformatf("v%0d_busy_n%0d", v, n), int'(bus.busy), 1);
                end
                bus.hit = 1'b0;
                for (int i = 0; i < vecs[v].len; i++) begin
                    int a;
                    logic [1:0] nc;
                    a  = int'(vecs[v].acts[2*i +: 2]);
                    nc = vecs[v].notes[2*i +: 2];
                    if (a != 0 && n + 1 == (i + WINDOW) * p + p / 2) begin
                        bus.hit = 1'b1;
                        bus.hit_code = (a == 1) ? nc : ((nc == 2'd1) ? 2'd2 : 2'd1);
                    end
                end
                cyc();
            end
            bus.hit = 1'b0;
            if (fin < 0) chk($sformatf("v%0d_timeout", v), 0, 1);
            chk($sformatf("v%0d_duration", v), fin + 1, vecs[v].dur);
            chk($sformatf("v%0d_finish_at_model", v), fin, nfin);
            chk($sformatf("v%0d_hits", v), hits, vecs[v].hits);
            chk($sformatf("v%0d_misses", v), misses, vecs[v].misses);
            chk($sformatf("v%0d_combo", v), int'(bus.combo), vecs[v].combo);
            chk($sformatf("v%0d_max", v), int'(bus.max_combo), vecs[v].mx);
            repeat (4) cyc();
            chk($sformatf("v%0d_finish_hold", v), int'({bus.finish, bus.busy}), 2);
            chk($sformatf("v%0d_combo_hold", v), int'(bus.combo), vecs[v].combo);
            bus.ack = 1'b1;
            cyc();
            bus.ack = 1'b0;
            chk($sformatf("v%0d_idle_after_ack", v), int'({bus.finish, bus.busy}), 0);
            chk($sformatf("v%0d_max_after_ack", v), int'(bus.max_combo), vecs[v].mx);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
